// File: rtl/riscv_mem_pkg.sv
// Shared types for the IF/DM memory arbiter: FSM states, request owner and
// the latched memory request. Struct fields are sized for the widest supported bus.
package riscv_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requests. Data wins by default;
// fetch is forced through once STARVE_MAX data grants have been made while it waited.
module mem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic if_valid,
    input  logic dm_valid,
    output logic if_grant,
    output logic dm_grant
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic             if_wins;

    assign if_wins  = if_valid && (!dm_valid || (starve_cnt_reg == CNT_MAX));
    assign if_grant = arb_en && if_wins;
    assign dm_grant = arb_en && dm_valid && !if_wins;

    // A fetch requester that drops its request forfeits any accumulated credit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
        end else if (!if_valid || if_grant) begin
            starve_cnt_reg <= '0;
        end else if (dm_grant && (starve_cnt_reg != CNT_MAX)) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the pipeline.
// One transaction in flight at a time; the response is routed back to its owner.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                dm_req_valid,
    input  logic                dm_req_we,
    input  logic [ADDR_W-1:0]   dm_req_addr,
    input  logic [DATA_W-1:0]   dm_req_wdata,
    input  logic [DATA_W/8-1:0] dm_req_be,
    output logic                dm_req_ready,
    output logic                dm_rsp_valid,
    output logic [DATA_W-1:0]   dm_rsp_rdata,
    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata
);

    import riscv_mem_pkg::*;

    arb_state_t state_reg;
    arb_owner_t owner_reg;
    mem_req_t   req_reg;
    mem_req_t   grant_req;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (state_reg == IDLE),
        .if_valid (if_req_valid),
        .dm_valid (dm_req_valid),
        .if_grant (if_req_ready),
        .dm_grant (dm_req_ready)
    );

    // Fetches are full-word reads, so they carry all byte enables and no data.
    always_comb begin
        grant_req = '0;
        if (dm_req_ready) begin
            grant_req.we    = dm_req_we;
            grant_req.addr  = MEM_ADDR_W'(dm_req_addr);
            grant_req.wdata = MEM_DATA_W'(dm_req_wdata);
            grant_req.be    = MEM_BE_W'(dm_req_be);
        end else begin
            grant_req.addr  = MEM_ADDR_W'(if_req_addr);
            grant_req.be    = '1;
        end
    end

    assign mem_req_we    = req_reg.we;
    assign mem_req_addr  = req_reg.addr[ADDR_W-1:0];
    assign mem_req_wdata = req_reg.wdata[DATA_W-1:0];
    assign mem_req_be    = req_reg.be[DATA_W/8-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_IF;
            req_reg       <= '0;
            mem_req_valid <= 1'b0;
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            dm_rsp_valid  <= 1'b0;
            dm_rsp_rdata  <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (if_req_ready || dm_req_ready) begin
                        req_reg       <= grant_req;
                        owner_reg     <= dm_req_ready ? OWN_DM : OWN_IF;
                        mem_req_valid <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        state_reg <= IDLE;
                        if (owner_reg == OWN_DM) begin
                            dm_rsp_valid <= 1'b1;
                            dm_rsp_rdata <= req_reg.we ? '0 : mem_rsp_rdata;
                        end else begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= mem_rsp_rdata;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
